// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - host/display bundle for the eight-digit seven-segment scanner
interface seg7_scan_if;
   logic [31:0] data_in;
   logic        load;
   logic [7:0]  digit_en;
   logic        blank_lz;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   // Host side: drives data and controls, observes the display pins.
   modport master (
      output data_in, load, digit_en, blank_lz,
      input  an, seg, frame_done
   );

   // Scanner side.
   modport slave (
      input  data_in, load, digit_en, blank_lz,
      output an, seg, frame_done
   );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - double-buffered multiplexed hex display scanner
module seg7_scan #(
   parameter int DIGITS = 8,
   parameter int DWELL  = 10
) (
   input  logic        clk,
   input  logic        rst,
   seg7_scan_if.slave  bus
);

   localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

   logic [CW-1:0] dwell_q, dwell_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [31:0]   pending_q, pending_d;
   logic          pend_q, pend_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;
   logic          fd_q, fd_d;

   logic          dwell_last;
   logic          boundary;
   logic [31:0]   nib_shift;
   logic [3:0]    nibble;
   logic [DIGITS-1:0] zero_above;
   logic          lit;

   // Segment patterns {dp,g,f,e,d,c,b,a}, active-low, dp kept off.
   function automatic logic [7:0] hex_decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign dwell_last = (dwell_q == DWELL_LAST);
   assign boundary   = dwell_last && (idx_q == 3'd7);

   // Scan position: dwell counter wraps each digit slot, digit index steps on the last dwell cycle.
   always_comb begin
      dwell_d = dwell_last ? '0 : dwell_q + 1'b1;
      idx_d   = dwell_last ? idx_q + 3'd1 : idx_q;
      fd_d    = boundary;
   end

   // Double buffer: loads park in pending, shadow swaps only at the frame boundary;
   // a load landing on the boundary itself goes straight to shadow.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      if (boundary && bus.load) begin
         shadow_d = bus.data_in;
         pend_d   = 1'b0;
      end else if (bus.load) begin
         pending_d = bus.data_in;
         pend_d    = 1'b1;
      end else if (boundary && pend_q) begin
         shadow_d = pending_q;
         pend_d   = 1'b0;
      end
   end

   // Display drive: ghost-guard blank on the first dwell cycle, otherwise light the
   // current digit unless disabled or a suppressed leading zero.
   always_comb begin
      nib_shift = shadow_q >> {idx_q, 2'b00};
      nibble    = nib_shift[3:0];
      for (int k = 0; k < DIGITS; k++) begin
         zero_above[k] = ((shadow_q >> (4 * k)) == 32'd0);
      end
      lit = (dwell_q != '0) && bus.digit_en[idx_q]
            && !(bus.blank_lz && (idx_q != 3'd0) && zero_above[idx_q]);
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (lit) begin
         an_d  = ~(8'h01 << idx_q);
         seg_d = hex_decode(nibble);
      end
   end

   // State and registered outputs; reset also discards any pending load.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q   <= '0;
         idx_q     <= 3'd0;
         shadow_q  <= 32'd0;
         pending_q <= 32'd0;
         pend_q    <= 1'b0;
         an_q      <= 8'hFF;
         seg_q     <= 8'hFF;
         fd_q      <= 1'b0;
      end else begin
         dwell_q   <= dwell_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         fd_q      <= fd_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan
module tb_seg7_scan;
   localparam int DWELL = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_scan_if bus ();
   seg7_scan #(.DIGITS(8), .DWELL(DWELL)) dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   logic [16:0] exp_q[$];
   logic [16:0] e;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic [2:0]  m_idx = 3'd0;
   int          m_dwell = 0;
   logic [31:0] m_shadow = 32'd0;
   logic [31:0] m_pending = 32'd0;
   logic        m_pend = 1'b0;

   function automatic logic [15:0] ref_out(input logic [2:0] i, input int d,
                                           input logic [31:0] sh, input logic [7:0] en,
                                           input logic blz);
      int ii;
      logic [3:0] nib;
      logic hidden;
      ii = int'(i);
      if (d == 0) return 16'hFFFF;
      nib = sh[ii*4 +: 4];
      hidden = blz && (ii != 0) && ((sh >> (ii * 4)) == 32'd0);
      if (!en[ii] || hidden) return 16'hFFFF;
      return {~(8'h01 << ii), seg_tab[nib]};
   endfunction

   // Reference model: predicts the outputs for this edge and advances its own state.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.push_back({8'hFF, 8'hFF, 1'b0});
         m_idx <= 3'd0; m_dwell <= 0; m_shadow <= 32'd0; m_pending <= 32'd0; m_pend <= 1'b0;
      end else begin
         exp_q.push_back({ref_out(m_idx, m_dwell, m_shadow, bus.digit_en, bus.blank_lz),
                          (m_idx == 3'd7) && (m_dwell == DWELL - 1)});
         m_dwell <= (m_dwell == DWELL - 1) ? 0 : m_dwell + 1;
         if (m_dwell == DWELL - 1) m_idx <= m_idx + 3'd1;
         if (m_idx == 3'd7 && m_dwell == DWELL - 1 && bus.load) begin
            m_shadow <= bus.data_in; m_pend <= 1'b0;
         end else if (bus.load) begin
            m_pending <= bus.data_in; m_pend <= 1'b1;
         end else if (m_idx == 3'd7 && m_dwell == DWELL - 1 && m_pend) begin
            m_shadow <= m_pending; m_pend <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.load = 1'b1; bus.data_in = 32'hDEAD_BEEF;
      bus.digit_en = 8'hFF; bus.blank_lz = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_reset: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         tests++;
         if (bus.an !== 8'hFF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
            fails++; $display("FAIL reset_state: got an=%h seg=%h fd=%b want FF FF 0", bus.an, bus.seg, bus.frame_done);
         end
      end
      bus.load = 1'b0; rst = 1'b0;
   endtask

   task automatic test_idle_scan();
      int lit = 0, bad_seg = 0, fd_cnt = 0, last_fd = -1, bad_period = 0;
      for (int c = 0; c < 160; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_idle: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (bus.an !== 8'hFF) begin
            lit++;
            if (bus.seg !== 8'hC0) bad_seg++;
         end
         if (bus.frame_done === 1'b1) begin
            if (last_fd >= 0 && c - last_fd != 80) bad_period++;
            last_fd = c; fd_cnt++;
         end
      end
      tests++;
      if (lit != 144) begin fails++; $display("FAIL idle_lit_cycles: got %0d want 144", lit); end
      tests++;
      if (bad_seg != 0) begin fails++; $display("FAIL idle_seg_c0: got %0d non-C0 want 0", bad_seg); end
      tests++;
      if (fd_cnt != 2 || bad_period != 0) begin
         fails++; $display("FAIL idle_frame_done: got %0d pulses %0d bad gaps want 2 and 0", fd_cnt, bad_period);
      end
   endtask

   task automatic test_load_mid();
      int bad_before = 0, d0 = 0, d1 = 0, others = 0, g = 0;
      bus.blank_lz = 1'b1;
      for (g = 0; g < 200 && m_idx != 3'd3; g++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_load_wait: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
      end
      tests++;
      if (m_idx != 3'd3) begin fails++; $display("FAIL load_wait_timeout: got idx %0d want 3", m_idx); end
      bus.data_in = 32'h0000_00A5; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      tests++;
      if ({bus.an, bus.seg, bus.frame_done} !== e) begin
         fails++; $display("FAIL sb_load_strobe: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
      end
      for (g = 0; g < 200; g++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_load_before: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (bus.an !== 8'hFF && !(bus.an === 8'hFE && bus.seg === 8'hC0)) bad_before++;
         if (e[0]) break;
      end
      tests++;
      if (bad_before != 0) begin fails++; $display("FAIL load_held_until_boundary: got %0d early cycles want 0", bad_before); end
      for (int c = 0; c < 80; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_load_after: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (bus.an === 8'hFE && bus.seg === 8'h92) d0++;
         else if (bus.an === 8'hFD && bus.seg === 8'h88) d1++;
         else if (bus.an !== 8'hFF) others++;
      end
      tests++;
      if (d0 != 9 || d1 != 9 || others != 0) begin
         fails++; $display("FAIL load_a5_frame: got d0=%0d d1=%0d other=%0d want 9 9 0", d0, d1, others);
      end
      bus.blank_lz = 1'b0;
   endtask

   task automatic test_back_to_back();
      int d7 = 0, early_f = 0, f0 = 0, f7 = 0, g = 0;
      for (g = 0; g < 200 && !(m_idx == 3'd7 && m_dwell == DWELL - 1); g++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_b2b_wait: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
      end
      tests++;
      if (!(m_idx == 3'd7 && m_dwell == DWELL - 1)) begin
         fails++; $display("FAIL b2b_wait_timeout: got idx %0d dwell %0d want 7 %0d", m_idx, m_dwell, DWELL - 1);
      end
      bus.data_in = 32'h1234_5678; bus.load = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         bus.load = (c == 2);
         if (c == 2) bus.data_in = 32'hFFFF_FFFF;
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_b2b_loads: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
      end
      for (int c = 0; c < 78; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_b2b_frame1: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (bus.an === 8'h7F && bus.seg === 8'hF9) d7++;
         if (bus.an !== 8'hFF && bus.seg === 8'h8E) early_f++;
      end
      tests++;
      if (d7 != 9 || early_f != 0) begin
         fails++; $display("FAIL boundary_load_frame: got d7=%0d earlyF=%0d want 9 0", d7, early_f);
      end
      for (int c = 0; c < 80; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_b2b_frame2: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (bus.an === 8'hFE && bus.seg === 8'h8E) f0++;
         if (bus.an === 8'h7F && bus.seg === 8'h8E) f7++;
      end
      tests++;
      if (f0 != 9 || f7 != 9) begin
         fails++; $display("FAIL second_load_frame: got d0=%0d d7=%0d want 9 9", f0, f7);
      end
   endtask

   task automatic test_digit_en();
      int an0_low = 0, lit = 0;
      bus.digit_en = 8'b1111_1110;
      for (int c = 0; c < 81; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_digit_en: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (c > 0) begin
            if (bus.an[0] === 1'b0) an0_low++;
            if (bus.an !== 8'hFF) lit++;
         end
      end
      tests++;
      if (an0_low != 0 || lit != 63) begin
         fails++; $display("FAIL digit_en_mask: got an0low=%0d lit=%0d want 0 63", an0_low, lit);
      end
      bus.digit_en = 8'hFF;
   endtask

   task automatic test_reset_mid();
      int g = 0, bad = 0;
      logic [7:0] first_an;
      for (g = 0; g < 200 && !(m_idx == 3'd2 && m_dwell == 3); g++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_rstmid_wait: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
      end
      bus.data_in = 32'h8888_8888; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      for (g = 0; g < 200 && !(m_idx == 3'd5 && m_dwell == 4); g++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_rstmid_wait5: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
      end
      tests++;
      if (!(m_idx == 3'd5 && m_dwell == 4)) begin fails++; $display("FAIL rstmid_timeout: got idx %0d want 5", m_idx); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (bus.an !== 8'hFF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
         fails++; $display("FAIL rstmid_dark: got an=%h seg=%h want FF FF", bus.an, bus.seg);
      end
      first_an = 8'hFF;
      for (int c = 0; c < 160; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_rstmid_after: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if (first_an === 8'hFF) first_an = bus.an;
         if (bus.an !== 8'hFF && bus.seg !== 8'hC0) bad++;
      end
      tests++;
      if (first_an !== 8'hFE) begin fails++; $display("FAIL rstmid_restart_idx0: got an=%h want FE", first_an); end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL rstmid_pending_dropped: got %0d non-C0 want 0", bad); end
   endtask

   task automatic test_ghost();
      int multi = 0, ff_cnt = 0, last_ff = -1, bad_gap = 0;
      for (int c = 0; c < 240; c++) begin
         tick();
         tests++;
         if ({bus.an, bus.seg, bus.frame_done} !== e) begin
            fails++; $display("FAIL sb_ghost: got %h want %h", {bus.an, bus.seg, bus.frame_done}, e);
         end
         if ($countones(~bus.an) > 1) multi++;
         if (bus.an === 8'hFF) begin
            if (bus.seg !== 8'hFF) bad_gap++;
            if (last_ff >= 0 && c - last_ff != DWELL) bad_gap++;
            last_ff = c; ff_cnt++;
         end
      end
      tests++;
      if (multi != 0) begin fails++; $display("FAIL ghost_onehot: got %0d multi-low want 0", multi); end
      tests++;
      if (ff_cnt != 24 || bad_gap != 0) begin
         fails++; $display("FAIL ghost_blank: got %0d blanks %0d bad want 24 0", ff_cnt, bad_gap);
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_load_mid();
      test_back_to_back();
      test_digit_en();
      test_reset_mid();
      test_ghost();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, fixed at 8 for this block.
REQ-002 Parameter DWELL, default 10: clk cycles per digit; with the 10 kHz CPU-side clock this gives 1 ms per digit and a 125 Hz frame.
REQ-003 clk  input  1  single clock (the divided 10 kHz clock); all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  32  eight hex nibbles; nibble k = data_in[4k+3:4k] drives digit k.
REQ-006 load  input  1  one-cycle strobe that captures data_in.
REQ-007 digit_en  input  8  per-digit enable; 0 forces that digit dark.
REQ-008 blank_lz  input  1  1 = suppress leading-zero digits.
REQ-009 an  output  8  anode selects, active-low, registered.
REQ-010 seg  output  8  {dp,g,f,e,d,c,b,a}, active-low, registered; dp always 1 (off).
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-012 dwell_cnt counts 0..DWELL-1 and wraps; idx (3 bits) increments when dwell_cnt = DWELL-1, with wrap 7 -> 0.
REQ-013 Frame boundary = cycle with idx = 7 and dwell_cnt = DWELL-1; frame_done is 1 on the following cycle only.
REQ-014 Double buffering: load writes data_in into pending and sets pend_flag; shadow drives the display.
REQ-015 At the frame boundary with pend_flag = 1: shadow <= pending and pend_flag <= 0; otherwise shadow holds.
REQ-016 load on the boundary cycle: data_in goes directly into shadow and pend_flag <= 0, so that load wins.
REQ-017 Back-to-back loads within one frame: the last one wins; earlier values are never displayed.
REQ-018 Leading-zero blank (blank_lz = 1): digit k is blanked if shadow nibbles k..7 are all zero; digit 0 is never blanked.
REQ-019 Ghost guard: on the cycle dwell_cnt = 0, next an = 8'hFF and next seg = 8'hFF.
REQ-020 Otherwise next an = ~(1 << idx) if digit_en[idx] = 1 and idx is not blanked; else 8'hFF.
REQ-021 Next seg = hex decode of shadow nibble idx when that digit is lit; else 8'hFF.
REQ-022 Decode table for 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex).
REQ-023 an and seg have one-cycle latency from (idx, dwell_cnt, shadow, digit_en, blank_lz).
REQ-024 At most one an bit is low in any cycle.
REQ-025 digit_en and blank_lz are sampled every cycle, are not buffered, and take effect on the next cycle.

Reset
REQ-026 When rst = 1 on a clk edge: an = 8'hFF, seg = 8'hFF, frame_done = 0, idx = 0, dwell_cnt = 0, shadow = 0, pending = 0, pend_flag = 0.
REQ-027 Reset mid-frame aborts the frame; a pending load is discarded; the scan restarts at idx 0 on the first cycle after rst falls.
REQ-028 load asserted while rst = 1 is ignored.

Verification
REQ-029 Reset then idle, digit_en = FF, blank_lz = 0 -> each digit k lit in turn with seg = C0; an low for DWELL-1 of every DWELL cycles; frame_done every 80 cycles.
REQ-030 load data_in = 32'h0000_00A5 mid-frame, blank_lz = 1 -> display unchanged until the boundary; next frame digit0 seg = 92, digit1 seg = 88, digits 2-7 an high.
REQ-031 load on the exact boundary cycle with 32'h1234_5678 -> the next frame shows it (digit7 seg = F9); a second load 32'hFFFF_FFFF three cycles later shows only in the following frame.
REQ-032 digit_en = 8'b1111_1110 -> an[0] never low; all other digits scan normally.
REQ-033 rst pulsed for 1 cycle while idx = 5 with a pending load -> an = FF and seg = FF on the next cycle; scan restarts at idx 0 showing 0 (C0); the pending value is never shown.
REQ-034 Ghost check over 3 frames -> every dwell_cnt = 0 cycle produces an = FF, and an is never low on two bits in one cycle.
